fft_frame_sequencer: RTL

- Sits between the audio_codec read interface and the streaming FFT core.
- Pops stereo samples from the codec and mixes them to mono.
- Frames the samples into FFT_LEN-point blocks with sink_valid/sop/eop and honours sink_ready backpressure.
- Consumes the FFT source stream, tracks the bin index and reports frame completion and stall conditions.

---
 rtl/fft_frame_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the stereo codec read port and a streaming FFT core.
// Mixes codec sample pairs to mono, frames them into FFT_LEN-point sink blocks
// with sop/eop under sink_ready backpressure, and tracks the FFT source stream.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | not running; no codec pops, source stream not accepted
// STREAM   | capturing codec samples and issuing sink beats for one frame
// WAIT_OUT | input frame sent; waiting for the FFT output frame to finish
module fft_frame_sequencer #(
   parameter int FFT_LEN    = 256,
   parameter int LOG2_LEN   = 8,
   parameter int DATA_W     = 24,
   parameter bit CONTINUOUS = 1'b1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                read_ready,
   input  logic [DATA_W-1:0]   readdata_left,
   input  logic [DATA_W-1:0]   readdata_right,
   output logic                read,
   output logic                sink_valid,
   input  logic                sink_ready,
   output logic                sink_sop,
   output logic                sink_eop,
   output logic [DATA_W-1:0]   sink_real,
   output logic [DATA_W-1:0]   sink_imag,
   output logic [1:0]          sink_error,
   input  logic                source_valid,
   input  logic                source_sop,
   input  logic                source_eop,
   output logic                source_ready,
   output logic [LOG2_LEN-1:0] bin_index,
   output logic                frame_done,
   output logic                stall_seen,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STREAM   = 2'd1,
      WAIT_OUT = 2'd2
   } state_t;

   localparam logic [LOG2_LEN-1:0] LAST_IDX = LOG2_LEN'(FFT_LEN - 1);

   state_t              state;
   state_t              state_nxt;
   logic [DATA_W-1:0]   hold;
   logic                hold_valid;
   logic [LOG2_LEN-1:0] count;
   logic [LOG2_LEN-1:0] bin_reg;
   logic [DATA_W:0]     mix_sum;
   logic [DATA_W-1:0]   mono;
   logic                capture;
   logic                beat_xfer;
   logic                eop_xfer;
   logic                src_acc;
   logic                src_eop_acc;
   logic                src_sop_acc;

   // One extra bit holds the full stereo sum; dropping bit 0 is an arithmetic
   // shift right by one, rounding toward minus infinity.
   assign mix_sum = {readdata_left[DATA_W-1], readdata_left}
                  + {readdata_right[DATA_W-1], readdata_right};
   assign mono    = mix_sum[DATA_W:1];

   assign sink_valid = hold_valid;
   assign sink_real  = hold;
   assign sink_imag  = '0;
   assign sink_error = 2'b00;
   assign sink_sop   = hold_valid & (count == '0);
   assign sink_eop   = hold_valid & (count == LAST_IDX);

   assign beat_xfer = hold_valid & sink_ready;
   assign eop_xfer  = beat_xfer & (count == LAST_IDX);

   // Once the eop beat is held, hold_valid blocks further capture until the
   // beat leaves, and that same edge moves the FSM to its next frame decision,
   // so no separate "frame captured" flag is needed.
   assign capture = (state == STREAM) & read_ready & ~hold_valid & ~read;

   assign src_acc     = source_valid & source_ready;
   assign src_sop_acc = src_acc & source_sop;
   assign src_eop_acc = src_acc & source_eop;

   // The sop beat is always bin 0; later beats show the running count.
   assign bin_index = src_sop_acc ? '0 : bin_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_nxt    = state;
      source_ready = 1'b0;
      busy         = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            source_ready = 1'b1;
            busy         = 1'b1;
            if (eop_xfer) begin
               if (CONTINUOUS) begin
                  state_nxt = enable ? STREAM : IDLE;
               end else begin
                  state_nxt = WAIT_OUT;
               end
            end
         end
         WAIT_OUT: begin
            source_ready = 1'b1;
            busy         = 1'b1;
            if (src_eop_acc) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sample hold, codec pop strobe and sink beat counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold       <= '0;
         hold_valid <= 1'b0;
         read       <= 1'b0;
         count      <= '0;
      end else begin
         read <= capture;
         if (capture) begin
            hold       <= mono;
            hold_valid <= 1'b1;
         end else if (beat_xfer) begin
            hold_valid <= 1'b0;
            count      <= (count == LAST_IDX) ? '0 : count + 1'b1;
         end
      end
   end

   // Sticky input-stall flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_seen <= 1'b0;
      end else if (hold_valid & ~sink_ready) begin
         stall_seen <= 1'b1;
      end
   end

   // Source-side bin tracking and frame completion pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bin_reg    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= src_eop_acc;
         if (src_acc) begin
            bin_reg <= source_sop ? LOG2_LEN'(1) : bin_reg + 1'b1;
         end
      end
   end

endmodule
